pipe_stage_regs: RTL and testbench

Pipeline register chain for the five-stage MIPS core: carries instruction word and PC from Fetch through Decode, Execute, Memory and Writeback. It consumes `stall` from the hazard-detection unit: it freezes F/D, injects a bubble into D/E and lets E/M and M/W drain. It feeds `IR_D`, `IR_E` and `IR_M` back to the hazard unit and drives the PC write-enable. It also keeps stall-cycle and retired-instruction counters for performance debugging.

---
 rtl/pipe_stage_regs_pkg.sv | 41 ++++
 rtl/pipe_stage_regs_stage_reg.sv | 43 ++++
 rtl/pipe_stage_regs.sv | 101 ++++++++++
 tb/tb_pipe_stage_regs.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_regs_pkg.sv
// Constants shared between the pipeline register chain and the hazard-detection unit.
package pipe_stage_regs_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } stage_t;

    function automatic logic is_nop(input logic [31:0] instr);
        return instr == NOP;
    endfunction

endpackage

// File: rtl/pipe_stage_regs_stage_reg.sv
// One 64-bit IR+PC pipeline register; clear (bubble) takes priority over enable.
module stage_reg
    import pipe_stage_regs_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] pc_i,
    output logic [31:0] ir_o,
    output logic [31:0] pc_o
);

    stage_t stage_d;
    stage_t stage_q;

    always_comb begin
        stage_d = stage_q;
        if (clr_i) begin
            stage_d.ir = NOP;
            stage_d.pc = 32'h0;
        end else if (en_i) begin
            stage_d.ir = ir_i;
            stage_d.pc = pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stage_q.ir <= NOP;
            stage_q.pc <= PC_RESET;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign ir_o = stage_q.ir;
    assign pc_o = stage_q.pc;

endmodule

// File: rtl/pipe_stage_regs.sv
// F/D, D/E, E/M, M/W register chain: a stall freezes D, bubbles E and lets M/W drain.
module pipe_stage_regs
    import pipe_stage_regs_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_F,
    input  logic [31:0] pc_F,
    output logic        pc_en,
    output logic [31:0] IR_D,
    output logic [31:0] IR_E,
    output logic [31:0] IR_M,
    output logic [31:0] IR_W,
    output logic [31:0] PC_D,
    output logic [31:0] PC_E,
    output logic [31:0] PC_M,
    output logic [31:0] PC_W,
    output logic [31:0] stall_cnt,
    output logic [31:0] retire_cnt
);

    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] retire_cnt_d;
    logic [31:0] retire_cnt_q;

    assign pc_en = ~stall;

    stage_reg #(.PC_RESET(PC_RESET)) u_reg_d (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (~stall),
        .clr_i  (1'b0),
        .ir_i   (instr_F),
        .pc_i   (pc_F),
        .ir_o   (IR_D),
        .pc_o   (PC_D)
    );

    stage_reg #(.PC_RESET(PC_RESET)) u_reg_e (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (1'b1),
        .clr_i  (stall),
        .ir_i   (IR_D),
        .pc_i   (PC_D),
        .ir_o   (IR_E),
        .pc_o   (PC_E)
    );

    stage_reg #(.PC_RESET(PC_RESET)) u_reg_m (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (1'b1),
        .clr_i  (1'b0),
        .ir_i   (IR_E),
        .pc_i   (PC_E),
        .ir_o   (IR_M),
        .pc_o   (PC_M)
    );

    stage_reg #(.PC_RESET(PC_RESET)) u_reg_w (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (1'b1),
        .clr_i  (1'b0),
        .ir_i   (IR_M),
        .pc_i   (PC_M),
        .ir_o   (IR_W),
        .pc_o   (PC_W)
    );

    // Bubbles and real sll $0,$0,0 are both zero, so neither counts as retired.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!is_nop(IR_M) && (retire_cnt_q != 32'hFFFF_FFFF)) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q  <= 32'h0;
            retire_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed-vector bench for pipe_stage_regs with hand-computed expected pipeline contents.
module tb_pipe_stage_regs;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] instr_F;
    logic [31:0] pc_F;
    logic        pc_en;
    logic [31:0] IR_D, IR_E, IR_M, IR_W;
    logic [31:0] PC_D, PC_E, PC_M, PC_W;
    logic [31:0] stall_cnt;
    logic [31:0] retire_cnt;

    int assertCount = 0;
    int failCount   = 0;

    localparam logic [31:0] INS_A = 32'h3C01_1234;
    localparam logic [31:0] INS_B = 32'h3421_5678;
    localparam logic [31:0] INS_X = 32'h2003_0005;
    localparam logic [31:0] INS_C = 32'h8C22_0000;
    localparam logic [31:0] INS_Y = 32'h0022_1820;
    localparam logic [31:0] INS_Z = 32'hAC02_0004;

    pipe_stage_regs dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .instr_F    (instr_F),
        .pc_F       (pc_F),
        .pc_en      (pc_en),
        .IR_D       (IR_D),
        .IR_E       (IR_E),
        .IR_M       (IR_M),
        .IR_W       (IR_W),
        .PC_D       (PC_D),
        .PC_E       (PC_E),
        .PC_M       (PC_M),
        .PC_W       (PC_W),
        .stall_cnt  (stall_cnt),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, check the combinational pc_en, then advance past the edge.
    task automatic applyStimulus(input logic st, input logic [31:0] ins, input logic [31:0] pc);
        stall   = st;
        instr_F = ins;
        pc_F    = pc;
        #1;
        checkOutput("pc_en", {31'h0, pc_en}, {31'h0, ~st});
        @(posedge clk);
        #1;
    endtask

    task automatic checkStage(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                              input logic [31:0] irExp, input logic [31:0] pcExp);
        checkOutput({tag, "_ir"}, ir, irExp);
        checkOutput({tag, "_pc"}, pc, pcExp);
    endtask

    initial begin
        reset   = 1'b0;
        stall   = 1'b1;
        instr_F = 32'hDEAD_BEEF;
        pc_F    = 32'h0000_1234;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0000_1234);
        checkStage("rst_D", IR_D, PC_D, 32'h0, 32'h3000);
        checkStage("rst_E", IR_E, PC_E, 32'h0, 32'h3000);
        checkStage("rst_M", IR_M, PC_M, 32'h0, 32'h3000);
        checkStage("rst_W", IR_W, PC_W, 32'h0, 32'h3000);
        checkOutput("rst_stall_cnt", stall_cnt, 32'h0);
        checkOutput("rst_retire_cnt", retire_cnt, 32'h0);

        // Free run
        reset = 1'b1;
        applyStimulus(1'b0, INS_A, 32'h3000);
        checkStage("fr1_D", IR_D, PC_D, INS_A, 32'h3000);
        applyStimulus(1'b0, INS_B, 32'h3004);
        checkStage("fr2_E", IR_E, PC_E, INS_A, 32'h3000);
        applyStimulus(1'b0, INS_X, 32'h3008);
        checkStage("fr3_M", IR_M, PC_M, INS_A, 32'h3000);
        checkOutput("fr3_retire", retire_cnt, 32'h0);
        applyStimulus(1'b0, INS_C, 32'h300C);
        checkStage("fr4_W", IR_W, PC_W, INS_A, 32'h3000);
        checkStage("fr4_D", IR_D, PC_D, INS_C, 32'h300C);
        checkOutput("fr4_retire", retire_cnt, 32'h1);

        // Single stall with lw in D
        applyStimulus(1'b1, INS_Y, 32'h3010);
        checkStage("s1_D", IR_D, PC_D, INS_C, 32'h300C);
        checkStage("s1_E", IR_E, PC_E, 32'h0, 32'h0);
        checkStage("s1_M", IR_M, PC_M, INS_X, 32'h3008);
        checkStage("s1_W", IR_W, PC_W, INS_B, 32'h3004);
        checkOutput("s1_stall_cnt", stall_cnt, 32'h1);
        checkOutput("s1_retire", retire_cnt, 32'h2);
        applyStimulus(1'b0, INS_Y, 32'h3010);
        checkStage("s1r_D", IR_D, PC_D, INS_Y, 32'h3010);
        checkStage("s1r_E", IR_E, PC_E, INS_C, 32'h300C);
        checkStage("s1r_M", IR_M, PC_M, 32'h0, 32'h0);
        checkStage("s1r_W", IR_W, PC_W, INS_X, 32'h3008);
        checkOutput("s1r_retire", retire_cnt, 32'h3);
        checkOutput("s1r_stall_cnt", stall_cnt, 32'h1);

        // Triple stall with Y held in D
        applyStimulus(1'b1, INS_Z, 32'h3014);
        checkStage("t1_D", IR_D, PC_D, INS_Y, 32'h3010);
        checkStage("t1_M", IR_M, PC_M, INS_C, 32'h300C);
        checkOutput("t1_stall_cnt", stall_cnt, 32'h2);
        checkOutput("t1_retire", retire_cnt, 32'h3);
        applyStimulus(1'b1, INS_Z, 32'h3014);
        checkStage("t2_D", IR_D, PC_D, INS_Y, 32'h3010);
        checkStage("t2_W", IR_W, PC_W, INS_C, 32'h300C);
        checkOutput("t2_stall_cnt", stall_cnt, 32'h3);
        checkOutput("t2_retire", retire_cnt, 32'h4);
        applyStimulus(1'b1, INS_Z, 32'h3014);
        checkStage("t3_D", IR_D, PC_D, INS_Y, 32'h3010);
        checkStage("t3_E", IR_E, PC_E, 32'h0, 32'h0);
        checkStage("t3_W", IR_W, PC_W, 32'h0, 32'h0);
        checkOutput("t3_stall_cnt", stall_cnt, 32'h4);
        applyStimulus(1'b0, INS_Z, 32'h3014);
        checkStage("t4_D", IR_D, PC_D, INS_Z, 32'h3014);
        checkStage("t4_E", IR_E, PC_E, INS_Y, 32'h3010);
        checkStage("t4_W", IR_W, PC_W, 32'h0, 32'h0);
        checkOutput("t4_retire", retire_cnt, 32'h4);
        applyStimulus(1'b0, 32'h0, 32'h3018);
        checkStage("t5_M", IR_M, PC_M, INS_Y, 32'h3010);
        checkStage("t5_W", IR_W, PC_W, 32'h0, 32'h0);
        checkOutput("t5_retire", retire_cnt, 32'h4);
        applyStimulus(1'b0, 32'h0, 32'h301C);
        checkStage("t6_W", IR_W, PC_W, INS_Y, 32'h3010);
        checkOutput("t6_retire", retire_cnt, 32'h5);
        checkOutput("t6_stall_cnt", stall_cnt, 32'h4);

        // Reset on the same edge as a stall
        reset = 1'b0;
        applyStimulus(1'b1, INS_A, 32'h3020);
        checkStage("rs_D", IR_D, PC_D, 32'h0, 32'h3000);
        checkStage("rs_E", IR_E, PC_E, 32'h0, 32'h3000);
        checkStage("rs_W", IR_W, PC_W, 32'h0, 32'h3000);
        checkOutput("rs_stall_cnt", stall_cnt, 32'h0);
        checkOutput("rs_retire", retire_cnt, 32'h0);
        reset = 1'b1;

        // Saturation of stall_cnt
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        #1;
        applyStimulus(1'b1, INS_A, 32'h3000);
        checkOutput("sat1_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
        applyStimulus(1'b1, INS_A, 32'h3000);
        checkOutput("sat2_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
        applyStimulus(1'b0, INS_A, 32'h3000);
        checkOutput("sat3_stall_cnt", stall_cnt, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
